// File: rtl/uart_rx_deserializer.sv
// Serial-in/parallel-out stage of the UART RX path: assembles LSB- or MSB-first frames of run-time length.
// Optional parity check on the bit after the last data bit when RXDESER_PARITY_CHK_EN is defined.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 2)
) (
    input  logic                  RxDeser_CLK,
    input  logic                  RxDeser_RST,
    input  logic                  RxDeser_SampledData,
    input  logic                  RxDeser_Sample_Valid,
    input  logic                  RxDeser_EN,
    input  logic                  RxDeser_MsbFirst,
    input  logic [CNT_WIDTH-1:0]  RxDeser_FrameLen,
    input  logic                  RxDeser_Ready,
    input  logic                  RxDeser_Clr_Ovr,
`ifdef RXDESER_PARITY_CHK_EN
    input  logic                  RxDeser_Par_Type,
`endif
    output logic [DATA_WIDTH-1:0] RxDeser_PDATA,
    output logic                  RxDeser_Valid,
    output logic                  RxDeser_Busy,
    output logic                  RxDeser_Ovr,
    output logic                  RxDeser_Par_Err
);

`ifdef RXDESER_PARITY_CHK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t                 state, state_nxt;
    logic [DATA_WIDTH-1:0]  shreg, shreg_nxt, shifted, frame_src, frame, mask;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nxt, cnt_inc, len_q, len_cur, len_in, shamt;
    logic                   msb_q, msb_cur, accept, done;
`ifdef RXDESER_PARITY_CHK_EN
    logic                   par_q, perr_nxt, par_err_q;
`endif

    // Out-of-range lengths fall back to a full-width frame.
    assign len_in  = (RxDeser_FrameLen == '0 || RxDeser_FrameLen > CNT_WIDTH'(DATA_WIDTH))
                   ? CNT_WIDTH'(DATA_WIDTH) : RxDeser_FrameLen;
    assign accept  = RxDeser_EN & RxDeser_Sample_Valid;
    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge RxDeser_CLK) begin
        if (RxDeser_RST) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        len_cur   = (state == IDLE) ? len_in : len_q;
        msb_cur   = (state == IDLE) ? RxDeser_MsbFirst : msb_q;
        shifted   = msb_cur ? {shreg[DATA_WIDTH-2:0], RxDeser_SampledData}
                            : {RxDeser_SampledData, shreg[DATA_WIDTH-1:1]};
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        done      = 1'b0;
        frame_src = shifted;
`ifdef RXDESER_PARITY_CHK_EN
        perr_nxt  = 1'b0;
`endif
        if (!RxDeser_EN) begin
            state_nxt = IDLE;
            shreg_nxt = '0;
            cnt_nxt   = '0;
        end else if (RxDeser_Sample_Valid) begin
            case (state)
`ifdef RXDESER_PARITY_CHK_EN
                PARITY: begin
                    frame_src = shreg;
                    perr_nxt  = ((^shreg) ^ RxDeser_SampledData) != par_q;
                    done      = 1'b1;
                    state_nxt = IDLE;
                    shreg_nxt = '0;
                    cnt_nxt   = '0;
                end
`endif
                default: begin
                    if (cnt_inc == len_cur) begin
`ifdef RXDESER_PARITY_CHK_EN
                        state_nxt = PARITY;
                        shreg_nxt = shifted;
                        cnt_nxt   = cnt_inc;
`else
                        done      = 1'b1;
                        state_nxt = IDLE;
                        shreg_nxt = '0;
                        cnt_nxt   = '0;
`endif
                    end else begin
                        state_nxt = SHIFT;
                        shreg_nxt = shifted;
                        cnt_nxt   = cnt_inc;
                    end
                end
            endcase
        end
        // LSB-first data sits at the top of shreg; MSB-first data is already right-aligned.
        shamt = CNT_WIDTH'(DATA_WIDTH) - len_cur;
        mask  = {DATA_WIDTH{1'b1}} >> shamt;
        frame = msb_cur ? (frame_src & mask) : (frame_src >> shamt);
    end

    always_ff @(posedge RxDeser_CLK) begin
        if (RxDeser_RST) begin
            shreg         <= '0;
            cnt           <= '0;
            len_q         <= '0;
            msb_q         <= 1'b0;
            RxDeser_PDATA <= '0;
            RxDeser_Valid <= 1'b0;
            RxDeser_Busy  <= 1'b0;
            RxDeser_Ovr   <= 1'b0;
`ifdef RXDESER_PARITY_CHK_EN
            par_q         <= 1'b0;
            par_err_q     <= 1'b0;
`endif
        end else begin
            shreg        <= shreg_nxt;
            cnt          <= cnt_nxt;
            RxDeser_Busy <= (state_nxt != IDLE);
            if (state == IDLE && accept) begin
                len_q <= len_in;
                msb_q <= RxDeser_MsbFirst;
`ifdef RXDESER_PARITY_CHK_EN
                par_q <= RxDeser_Par_Type;
`endif
            end
            if (done && (!RxDeser_Valid || RxDeser_Ready)) begin
                RxDeser_PDATA <= frame;
                RxDeser_Valid <= 1'b1;
`ifdef RXDESER_PARITY_CHK_EN
                par_err_q     <= perr_nxt;
`endif
            end else if (RxDeser_Valid && RxDeser_Ready) begin
                RxDeser_Valid <= 1'b0;
            end
            // A set on the same edge as a clear wins.
            if (done && RxDeser_Valid && !RxDeser_Ready) RxDeser_Ovr <= 1'b1;
            else if (RxDeser_Clr_Ovr)                    RxDeser_Ovr <= 1'b0;
        end
    end

`ifdef RXDESER_PARITY_CHK_EN
    assign RxDeser_Par_Err = par_err_q;
`else
    assign RxDeser_Par_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomized + directed bench for uart_rx_deserializer against a queue-based frame model.
module tb_uart_rx_deserializer;
    localparam int DW = 8;
    localparam int CW = $clog2(DW + 2);
`ifdef RXDESER_PARITY_CHK_EN
    localparam int PX = 1;
`else
    localparam int PX = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1, sbit = 1'b0, sv = 1'b0, en = 1'b0, msb = 1'b0;
    logic [CW-1:0] flen = '0;
    logic          ready = 1'b0, clr = 1'b0, ptype = 1'b0;
    logic [DW-1:0] pdata;
    logic          valid, busy, ovr, perr;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_deserializer #(.DATA_WIDTH(DW)) dut (
        .RxDeser_CLK          (clk),
        .RxDeser_RST          (rst),
        .RxDeser_SampledData  (sbit),
        .RxDeser_Sample_Valid (sv),
        .RxDeser_EN           (en),
        .RxDeser_MsbFirst     (msb),
        .RxDeser_FrameLen     (flen),
        .RxDeser_Ready        (ready),
        .RxDeser_Clr_Ovr      (clr),
`ifdef RXDESER_PARITY_CHK_EN
        .RxDeser_Par_Type     (ptype),
`endif
        .RxDeser_PDATA        (pdata),
        .RxDeser_Valid        (valid),
        .RxDeser_Busy         (busy),
        .RxDeser_Ovr          (ovr),
        .RxDeser_Par_Err      (perr)
    );

    // Reference: bits of the current frame collected in arrival order.
    bit            q[$];
    bit            m_active = 1'b0, m_msb = 1'b0, m_ptype = 1'b0;
    int            m_len = 0;
    logic [DW-1:0] m_pdata = '0;
    logic          m_valid = 1'b0, m_busy = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit           done = 1'b0;
        bit           ovr_set = 1'b0;
        logic [15:0]  val = '0;
        logic         pe = 1'b0;
        if (rst) begin
            q.delete();
            m_active = 0; m_pdata = '0; m_valid = 0; m_busy = 0; m_ovr = 0; m_perr = 0;
            return;
        end
        if (!en) begin
            q.delete();
            m_active = 0;
        end else if (sv) begin
            if (!m_active) begin
                m_active = 1;
                m_len    = (flen == 0 || int'(flen) > DW) ? DW : int'(flen);
                m_msb    = msb;
                m_ptype  = ptype;
            end
            q.push_back(sbit);
            if (q.size() == m_len + PX) begin
                done = 1;
                for (int i = 0; i < m_len; i++)
                    if (m_msb) val = (val << 1) | 16'(q[i]);
                    else       val = val + (16'(q[i]) << i);
                if (PX == 1) pe = ((^val) ^ q[m_len]) != m_ptype;
                q.delete();
                m_active = 0;
            end
        end
        if (done) begin
            if (!m_valid || ready) begin
                m_pdata = val[DW-1:0];
                m_valid = 1;
                m_perr  = pe;
            end else ovr_set = 1;
        end else if (m_valid && ready) m_valid = 0;
        if (ovr_set)  m_ovr = 1;
        else if (clr) m_ovr = 0;
        m_busy = m_active;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("pdata", 32'(pdata), 32'(m_pdata));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("busy",  32'(busy),  32'(m_busy));
        chk("ovr",   32'(ovr),   32'(m_ovr));
        chk("perr",  32'(perr),  32'(m_perr));
    endtask

    // arr[i] is the i-th bit to arrive; ready only on the last strobe.
    task automatic send(input logic [15:0] arr, input int n, input logic msb_i,
                        input logic [CW-1:0] len_i, input logic rdy_last);
        for (int i = 0; i < n; i++) begin
            en = 1; sv = 1; sbit = arr[i]; msb = msb_i; flen = len_i;
            ready = (i == n - 1) ? rdy_last : 1'b0;
            tick();
        end
        sv = 0; ready = 0;
    endtask

    task automatic frame(input logic [15:0] arr, input int nd, input logic msb_i,
                         input logic [CW-1:0] len_i, input logic rdy_last, input logic pbit);
        logic [15:0] a;
        a = arr;
        if (PX == 1) a[nd] = pbit;
        send(a, nd + PX, msb_i, len_i, rdy_last);
    endtask

    task automatic consume();
        ready = 1; tick(); ready = 0;
    endtask

    initial begin
        @(negedge clk);
        rst = 1; tick();
        chk("rst_valid", 32'(valid), 32'd0);
        rst = 0; en = 1; tick();

        frame(16'hA5, 8, 0, CW'(8), 0, 0);
        chk("lsb_a5", 32'(pdata), 32'hA5);
        chk("lsb_a5_valid", 32'(valid), 32'd1);
        consume();
        chk("ready_clears", 32'(valid), 32'd0);

        frame(16'hA5, 8, 1, CW'(8), 0, 0);
        chk("msb_a5", 32'(pdata), 32'hA5);
        consume();
        frame(16'h03, 8, 0, CW'(8), 0, 0);
        chk("lsb_03", 32'(pdata), 32'h03);
        consume();
        frame(16'h03, 8, 1, CW'(8), 0, 0);
        chk("msb_c0", 32'(pdata), 32'hC0);
        consume();

        frame(16'h0B, 5, 0, CW'(5), 0, 0);
        chk("len5", 32'(pdata), 32'h0B);
        chk("len5_top", 32'(pdata[7:5]), 32'd0);
        consume();
        frame(16'h3C, 8, 0, CW'(0), 0, 0);
        chk("len0", 32'(pdata), 32'h3C);
        consume();

        frame(16'h11, 8, 0, CW'(8), 0, 0);
        frame(16'h22, 8, 0, CW'(8), 0, 0);
        chk("ovr_hold", 32'(pdata), 32'h11);
        chk("ovr_set", 32'(ovr), 32'd1);
        clr = 1; tick(); clr = 0;
        chk("ovr_clr", 32'(ovr), 32'd0);
        frame(16'h22, 8, 0, CW'(8), 1, 0);
        chk("swap_data", 32'(pdata), 32'h22);
        chk("swap_ovr", 32'(ovr), 32'd0);
        chk("swap_valid", 32'(valid), 32'd1);
        consume();

        send(16'h0005, 3, 0, CW'(8), 0);
        en = 0; tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        en = 1;
        frame(16'h5A, 8, 0, CW'(8), 0, 0);
        chk("after_abort", 32'(pdata), 32'h5A);
        send(16'h0007, 3, 0, CW'(8), 0);
        rst = 1; tick(); rst = 0;
        chk("rst_pdata", 32'(pdata), 32'd0);
        chk("rst_valid2", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

`ifdef RXDESER_PARITY_CHK_EN
        ptype = 0;
        frame(16'hA5, 8, 0, CW'(8), 0, 0);
        chk("par_even_ok", 32'(perr), 32'd0);
        consume();
        frame(16'hA5, 8, 0, CW'(8), 0, 1);
        chk("par_even_bad", 32'(perr), 32'd1);
        consume();
        ptype = 1;
        frame(16'hA5, 8, 0, CW'(8), 0, 1);
        chk("par_odd_ok", 32'(perr), 32'd0);
        consume();
`endif

        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            en    = ($urandom_range(0, 24) != 0);
            sv    = $urandom_range(0, 1);
            sbit  = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) msb = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) flen = CW'($urandom_range(0, 11));
            ready = ($urandom_range(0, 2) == 0);
            clr   = ($urandom_range(0, 9) == 0);
            ptype = $urandom_range(0, 1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
